// File: rtl/bcd_display_driver.sv
// bcd_display_driver: sequential binary-to-decimal seven-segment driver.
// A loaded binary value is converted to BCD by a shift-add-3 engine, one
// bit per cycle. The result is registered as NUM_DIGITS active-low 7-segment
// patterns. Values that need more than NUM_DIGITS decimal digits show a dash
// on every digit and raise overflow.
//
// Optional feature macro: SEG_LEADING_ZERO_BLANK_EN. When it is defined,
// leading zero digits are blanked. Digit 0 is never blanked.
//
// Handshake: load is a request that is taken only while busy is low (IDLE).
// A load seen while busy is high is dropped; it is not queued. done pulses
// high for one cycle when hex_out and overflow take their new values.
// busy is high from the cycle after an accepted load until the cycle done
// rises.
module bcd_display_driver #(
  parameter int NUM_DIGITS = 6,
  parameter int BIN_WIDTH  = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BIN_WIDTH-1:0]    value,
  input  logic                    load,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic [1:0]              o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  // Largest value that fits in NUM_DIGITS decimal digits, in 64-bit math.
  function automatic logic [63:0] max_decimal(input int digits);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_decimal(NUM_DIGITS);

  // Active-low segment pattern: bit0 = a ... bit6 = g.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  state_t                  r_state;
  state_t                  w_next_state;
  logic [BIN_WIDTH-1:0]    r_shift;
  logic [BCD_W-1:0]        r_bcd;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_ovf_pending;
  logic                    r_done;
  logic                    r_overflow;
  logic [7*NUM_DIGITS-1:0] r_hex;
  logic [BCD_W-1:0]        w_bcd_adj;
  logic [7*NUM_DIGITS-1:0] w_hex;
`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic                    w_lead_seen;
`endif

  // State register; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic: IDLE -> SHIFT on load, BIN_WIDTH shifts, one DONE cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (load) w_next_state = S_SHIFT;
      S_SHIFT: if (r_cnt == CNT_W'(1)) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Add-3 correction for every BCD nibble that is 5 or more, before the shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
  end

  // Segment decode of the finished BCD digits, optionally blanking leading zeros.
  always_comb begin
    w_hex = '0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    w_lead_seen = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (r_bcd[4*k +: 4] != 4'd0) w_lead_seen = 1'b1;
      if (!w_lead_seen && (k != 0)) w_hex[7*k +: 7] = 7'h7F;
      else                          w_hex[7*k +: 7] = seg7(r_bcd[4*k +: 4]);
    end
`else
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_hex[7*k +: 7] = seg7(r_bcd[4*k +: 4]);
    end
`endif
  end

  // Datapath: capture on load, shift-add-3 in SHIFT, publish the result in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift       <= '0;
      r_bcd         <= '0;
      r_cnt         <= '0;
      r_ovf_pending <= 1'b0;
      r_done        <= 1'b0;
      r_overflow    <= 1'b0;
      r_hex         <= {NUM_DIGITS{7'h7F}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_shift       <= value;
            r_bcd         <= '0;
            r_cnt         <= CNT_W'(BIN_WIDTH);
            r_ovf_pending <= (64'(value) > MAX_VAL);
          end
        end
        S_SHIFT: begin
          {r_bcd, r_shift} <= {w_bcd_adj, r_shift} << 1;
          r_cnt            <= r_cnt - CNT_W'(1);
        end
        S_DONE: begin
          r_hex      <= r_ovf_pending ? {NUM_DIGITS{7'h3F}} : w_hex;
          r_overflow <= r_ovf_pending;
          r_done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign overflow    = r_overflow;
  assign hex_out     = r_hex;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Testbench for bcd_display_driver: directed vectors on a default-size
// instance (6 digits, 20 bits) and a small instance (1 digit, 4 bits).
// A scoreboard queue holds the expected {overflow, hex_out} for each
// conversion. Each done pulse pops one entry from the queue and compares it.
module tb_bcd_display_driver;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        load, load2;
  logic [19:0] value;
  logic [3:0]  value2;
  logic        busy, done, overflow;
  logic [41:0] hex_out;
  logic [1:0]  dbg_state;
  logic        busy2, done2, overflow2;
  logic [6:0]  hex_out2;
  logic [1:0]  dbg_state2;

  bcd_display_driver #(.NUM_DIGITS(6), .BIN_WIDTH(20)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .busy(busy), .done(done), .overflow(overflow), .hex_out(hex_out),
    .o_dbg_state(dbg_state)
  );

  bcd_display_driver #(.NUM_DIGITS(1), .BIN_WIDTH(4)) dut_small (
    .clk(clk), .reset(reset), .value(value2), .load(load2),
    .busy(busy2), .done(done2), .overflow(overflow2), .hex_out(hex_out2),
    .o_dbg_state(dbg_state2)
  );

  // ---------------- expected patterns (hand-computed) ----------------
  localparam logic [41:0] HEX_BLANK  = {6{7'h7F}};
  localparam logic [41:0] HEX_DASH   = {6{7'h3F}};
  localparam logic [41:0] HEX_123456 = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
  localparam logic [41:0] HEX_999999 = {6{7'h10}};
`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam logic [41:0] HEX_0  = {{5{7'h7F}}, 7'h40};
  localparam logic [41:0] HEX_7  = {{5{7'h7F}}, 7'h78};
  localparam logic [41:0] HEX_42 = {{4{7'h7F}}, 7'h19, 7'h24};
  localparam logic [41:0] HEX_99 = {{4{7'h7F}}, 7'h10, 7'h10};
  localparam logic [41:0] HEX_5  = {{5{7'h7F}}, 7'h12};
`else
  localparam logic [41:0] HEX_0  = {6{7'h40}};
  localparam logic [41:0] HEX_7  = {{5{7'h40}}, 7'h78};
  localparam logic [41:0] HEX_42 = {{4{7'h40}}, 7'h19, 7'h24};
  localparam logic [41:0] HEX_99 = {{4{7'h40}}, 7'h10, 7'h10};
  localparam logic [41:0] HEX_5  = {{5{7'h40}}, 7'h12};
`endif

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [42:0] exp_q[$];
  logic [7:0]  exp_q2[$];
  logic [42:0] sb_e;
  logic [7:0]  sb_e2;

  // Compare each done pulse against the oldest expected result.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) check("unexpected_done", 1, 0);
      else begin
        sb_e = exp_q.pop_front();
        check("sb_hex", hex_out, sb_e[41:0]);
        check("sb_ovf", overflow, sb_e[42]);
      end
    end
    if (done2) begin
      if (exp_q2.size() == 0) check("unexpected_done2", 1, 0);
      else begin
        sb_e2 = exp_q2.pop_front();
        check("sb2_hex", hex_out2, sb_e2[6:0]);
        check("sb2_ovf", overflow2, sb_e2[7]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // These tasks start and end 1 time unit after a rising edge.
  task automatic start_load(input bit sel, input logic [19:0] v);
    if (sel) begin value2 = v[3:0]; load2 = 1'b1; end
    else     begin value  = v;      load  = 1'b1; end
    @(posedge clk); #1;
    load  = 1'b0;
    load2 = 1'b0;
  endtask

  // Wait for done after the load edge. Optionally hold load high at the
  // given cycle offsets while the conversion is running.
  task automatic wait_done(input bit sel, input string tag, input int exp_lat,
                           input int inj_a, input int inj_b);
    int cyc;
    int bcnt;
    bit seen;
    cyc  = 0;
    bcnt = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      if (sel ? busy2 : busy) bcnt++;
      if (!sel) load = ((inj_a != 0) && (cyc + 1 == inj_a)) ||
                       ((inj_b != 0) && (cyc + 1 == inj_b));
      @(posedge clk); #1;
      cyc++;
      seen = sel ? done2 : done;
    end
    load = 1'b0;
    check({tag, "_latency"}, seen ? cyc : 999, exp_lat);
    check({tag, "_busy_cycles"}, bcnt, exp_lat);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; load = 1'b0; load2 = 1'b0; value = '0; value2 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_hex", hex_out, HEX_BLANK);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", overflow, 0);
    check("rst_hex2", hex_out2, 7'h7F);
    check("rst_busy2", busy2, 0);

    // Main conversion: 123456.
    exp_q.push_back({1'b0, HEX_123456});
    start_load(1'b0, 20'd123456);
    wait_done(1'b0, "t123456", 21, 0, 0);
    check("t123456_hex", hex_out, HEX_123456);
    check("t123456_ovf", overflow, 0);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("hex_hold_idle", hex_out, HEX_123456);

    // Zero, and the largest value that still fits.
    exp_q.push_back({1'b0, HEX_0});
    start_load(1'b0, 20'd0);
    wait_done(1'b0, "t0", 21, 0, 0);
    exp_q.push_back({1'b0, HEX_999999});
    start_load(1'b0, 20'd999999);
    wait_done(1'b0, "t999999", 21, 0, 0);

    // Overflow, then recovery to a small value.
    exp_q.push_back({1'b1, HEX_DASH});
    start_load(1'b0, 20'd1000000);
    wait_done(1'b0, "t1000000", 21, 0, 0);
    check("ovf_set", overflow, 1);
    exp_q.push_back({1'b0, HEX_7});
    start_load(1'b0, 20'd7);
    wait_done(1'b0, "t7", 21, 0, 0);
    check("ovf_clear", overflow, 0);

    // Loads while busy are ignored; a load right after done is accepted.
    exp_q.push_back({1'b0, HEX_42});
    start_load(1'b0, 20'd42);
    value = 20'd99;
    wait_done(1'b0, "t42", 21, 3, 20);
    exp_q.push_back({1'b0, HEX_99});
    start_load(1'b0, 20'd99);
    wait_done(1'b0, "t99", 21, 0, 0);

    // Reset in the middle of a conversion aborts it, with no done pulse.
    start_load(1'b0, 20'd555555);
    repeat (9) @(posedge clk);
    #1;
    check("hex_hold_shift", hex_out, HEX_99);
    check("busy_mid", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_hex", hex_out, HEX_BLANK);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_state", dbg_state, 0);
    repeat (25) @(posedge clk);
    #1;
    exp_q.push_back({1'b0, HEX_5});
    start_load(1'b0, 20'd5);
    wait_done(1'b0, "t5", 21, 0, 0);

    // When load and reset are both high in the same cycle, reset wins.
    value = 20'd123; load = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; reset = 1'b0;
    check("rst_beats_load", busy, 0);

    // Small instance: 1 digit, 4 bits.
    exp_q2.push_back({1'b0, 7'h10});
    start_load(1'b1, 20'd9);
    wait_done(1'b1, "s9", 5, 0, 0);
    exp_q2.push_back({1'b1, 7'h3F});
    start_load(1'b1, 20'd10);
    wait_done(1'b1, "s10", 5, 0, 0);
    check("s10_ovf", overflow2, 1);
    exp_q2.push_back({1'b0, 7'h40});
    start_load(1'b1, 20'd0);
    wait_done(1'b1, "s0", 5, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", exp_q.size() + exp_q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
